// File: rtl/nios_lcd_driver.sv
// Avalon-MM slave that queues character-LCD commands in a 4-deep FIFO and
// replays them onto the LCD bus with programmable setup/pulse/hold/execute timing.
module nios_lcd_driver #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 76000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) instructions need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && (data >= 8'h01) && (data <= 8'h03);
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, EXEC_CYC)), LONG_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 32'sd1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 32'sd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_load_s;
    logic             cnt_zero_s;

    logic [8:0]       fifo_mem_r [4];
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic [2:0]       level_r;
    logic             overflow_r;

    logic             wr_strobe_s;
    logic             push_req_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             full_s;
    logic             busy_s;
    logic [8:0]       head_s;

    logic [7:0]       lcd_data_r;
    logic             lcd_rs_r;
    logic             lcd_en_r;
    logic             unused_s;

    assign wr_strobe_s = chipselect & ~write_n;
    assign push_req_s  = wr_strobe_s & ~address[1];
    assign full_s      = (level_r == 3'd4);
    assign push_s      = push_req_s & (~full_s | pop_s);
    assign ovf_set_s   = push_req_s & full_s & ~pop_s;
    assign ovf_clr_s   = wr_strobe_s & (address == 2'd2) & writedata[2];
    assign busy_s      = (state_r != IDLE) | (level_r != 3'd0);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign cnt_zero_s  = (cnt_r == CNT_ZERO);
    assign unused_s    = ^writedata[31:8];

    assign lcd_data = lcd_data_r;
    assign lcd_rs   = lcd_rs_r;
    assign lcd_en   = lcd_en_r;
    assign lcd_rw   = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: each timed phase advances when its counter reaches zero.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (level_r != 3'd0) state_nxt_s = SETUP; else state_nxt_s = IDLE;
            SETUP:   if (cnt_zero_s) state_nxt_s = PULSE; else state_nxt_s = SETUP;
            PULSE:   if (cnt_zero_s) state_nxt_s = HOLD;  else state_nxt_s = PULSE;
            HOLD:    if (cnt_zero_s) state_nxt_s = EXEC;  else state_nxt_s = HOLD;
            EXEC:    if (cnt_zero_s) state_nxt_s = IDLE;  else state_nxt_s = EXEC;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop and phase-counter reload for the next phase.
    always_comb begin
        pop_s          = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = CNT_ZERO;
        case (state_r)
            IDLE: begin
                if (level_r != 3'd0) begin
                    pop_s          = 1'b1;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SETUP_LD;
                end else begin
                    pop_s          = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_zero_s) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = PULSE_LD;
                end else begin
                    cnt_load_s     = 1'b0;
                end
            end
            PULSE: begin
                if (cnt_zero_s) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = HOLD_LD;
                end else begin
                    cnt_load_s     = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_zero_s) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = is_long_cmd(lcd_rs_r, lcd_data_r) ? LONG_LD : EXEC_LD;
                end else begin
                    cnt_load_s     = 1'b0;
                end
            end
            EXEC:    cnt_load_s = 1'b0;
            default: cnt_load_s = 1'b0;
        endcase
    end

    // Phase down-counter; parks at zero when nothing reloads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_load_s) begin
            cnt_r <= cnt_load_val_s;
        end else if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Command FIFO storage, pointers and fill level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) fifo_mem_r[i] <= 9'd0;
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            level_r  <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {address[0], writedata[7:0]};
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 3'd1;
                2'b01:   level_r <= level_r - 3'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow flag; a same-cycle set beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr_s) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // LCD bus registers: data/rs latch on pop and hold until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_data_r <= 8'h00;
            lcd_rs_r   <= 1'b0;
            lcd_en_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                {lcd_rs_r, lcd_data_r} <= head_s;
            end
            lcd_en_r <= (state_nxt_s == PULSE);
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            2'd2:    readdata = {25'd0, level_r, 1'b0, overflow_r, full_s, busy_s};
            default: readdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_nios_lcd_driver.sv
// Bench for nios_lcd_driver: expected LCD words (and spacing) are queued as
// commands are written and checked at each lcd_en rising edge.
`timescale 1ns/1ps
module tb_nios_lcd_driver;

    typedef struct packed {
        logic [8:0]  word;
        logic [31:0] gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;

    nios_lcd_driver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd, input bit accept, input int gap);
        exp_t e;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = wd;
        if (accept) begin
            e.word = {a[0], wd[7:0]};
            e.gap  = gap;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops on every lcd_en rise, checks pulse width on fall.
    logic   en_prev   = 1'b0;
    longint last_rise = -1;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            last_rise = -1;
            en_prev   = 1'b0;
        end else begin
            if (lcd_en && !en_prev) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_en", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("lcd_word", {23'd0, lcd_rs, lcd_data}, {23'd0, e.word});
                    if (e.gap != 32'd0 && last_rise >= 0)
                        check_eq("en_gap", 32'(cyc - last_rise), e.gap);
                end
                last_rise = cyc;
            end else if (!lcd_en && en_prev) begin
                check_eq("en_width", 32'(cyc - last_rise), 32'd12);
            end
            en_prev = lcd_en;
        end
    end

    initial begin
        logic [31:0] v;
        int          cnt;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        #1;
        check_eq("rst_en",   {31'd0, lcd_en},  32'd0);
        check_eq("rst_data", {24'd0, lcd_data}, 32'd0);
        check_eq("rst_rs",   {31'd0, lcd_rs},  32'd0);
        check_eq("rst_rw",   {31'd0, lcd_rw},  32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd2, v);
        check_eq("rst_status", v, 32'h0);

        // Single instruction: latency, busy window.
        wr(2'd0, 32'hDEAD_BE38, 1'b1, 0);
        rd(2'd2, v);
        check_eq("st_after_push", v, 32'h11);
        cnt = 1;
        @(negedge clk);
        check_eq("pop_data", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b0, 8'h38});
        check_eq("setup_en", {31'd0, lcd_en}, 32'd0);
        rd(2'd2, v);
        check_eq("st_setup", v, 32'h01);
        cnt = 2;
        while (cnt < 3000) begin
            @(negedge clk);
            rd(2'd2, v);
            if (v[0] == 1'b0) break;
            cnt++;
        end
        check_eq("busy_cycles", cnt, 32'd2017);
        check_eq("sb_empty_single", exp_q.size(), 32'd0);
        check_eq("idle_hold", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b0, 8'h38});

        // Status decode with two queued entries.
        do_reset();
        wr(2'd0, 32'h10, 1'b1, 0);
        wr(2'd0, 32'h11, 1'b1, 2017);
        wr(2'd1, 32'h12, 1'b1, 2017);
        rd(2'd2, v); check_eq("st_two_queued", v, 32'h21);
        rd(2'd0, v); check_eq("rd_addr0", v, 32'h0);
        rd(2'd1, v); check_eq("rd_addr1", v, 32'h0);
        rd(2'd3, v); check_eq("rd_addr3", v, 32'h0);

        // Overflow: six back-to-back writes, sixth dropped.
        do_reset();
        for (int i = 0; i < 6; i++) wr(2'd0, 32'h30 + i, (i < 5), (i == 0) ? 0 : 2017);
        rd(2'd2, v); check_eq("st_overflow", v, 32'h47);
        wr(2'd2, 32'hFFFF_FFFB, 1'b0, 0);
        rd(2'd2, v); check_eq("ovf_other_bits", v, 32'h47);
        wr(2'd2, 32'h0000_0004, 1'b0, 0);
        rd(2'd2, v); check_eq("ovf_cleared", v, 32'h43);

        // Reset in the middle of the enable pulse.
        cnt = 0;
        while (!lcd_en && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("pulse_reached", {31'd0, lcd_en}, 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("async_rst_en",   {31'd0, lcd_en},  32'd0);
        check_eq("async_rst_data", {24'd0, lcd_data}, 32'd0);
        check_eq("async_rst_rs",   {31'd0, lcd_rs},  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd2, v); check_eq("st_after_rst", v, 32'h0);

        // Write without chipselect has no effect.
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 2'd0;
        writedata  = 32'h55;
        @(negedge clk);
        write_n = 1'b1;
        repeat (5) @(negedge clk);
        rd(2'd2, v); check_eq("no_cs_write", v, 32'h0);

        // Push coinciding with the pop of a full FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h20 + i, 1'b1, (i == 0) ? 0 : 2017);
        repeat (2013) @(negedge clk);
        wr(2'd1, 32'h25, 1'b1, 2017);
        rd(2'd2, v); check_eq("coincide_status", v, 32'h43);
        cnt = 0;
        while (exp_q.size() == 5 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("coincide_next_rise", exp_q.size(), 32'd4);

        // Clear instruction followed by a data write: long execute wait.
        do_reset();
        wr(2'd0, 32'h01, 1'b1, 0);
        wr(2'd1, 32'h41, 1'b1, 76017);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 80000) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("clear_drain", exp_q.size(), 32'd0);
        repeat (16) @(negedge clk);
        check_eq("final_data", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b1, 8'h41});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
